// File: rtl/apb_initiator_pkg.sv
// Shared types and constants for the APB initiator: FSM encoding, default widths,
// and the timer register file offsets used by benches and sequencers.
package apb_initiator_pkg;

    localparam int APB_ADDR_W      = 12;
    localparam int APB_DATA_W      = 32;
    localparam int APB_TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [APB_ADDR_W-1:0] TCR   = 12'h000;
    localparam logic [APB_ADDR_W-1:0] TDR0  = 12'h004;
    localparam logic [APB_ADDR_W-1:0] TDR1  = 12'h008;
    localparam logic [APB_ADDR_W-1:0] TCMP0 = 12'h00C;
    localparam logic [APB_ADDR_W-1:0] TCMP1 = 12'h010;
    localparam logic [APB_ADDR_W-1:0] TIER  = 12'h014;
    localparam logic [APB_ADDR_W-1:0] TISR  = 12'h018;
    localparam logic [APB_ADDR_W-1:0] THCSR = 12'h01C;

endpackage

// File: rtl/apb_initiator_if.sv
// Command/response handshake plus APB4 bus of the initiator; master = initiator side.
interface apb_initiator_if
    import apb_initiator_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_write;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [DATA_W-1:0]   cmd_wdata;
    logic [DATA_W/8-1:0] cmd_strb;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                rsp_err;
    logic                rsp_timeout;

    logic                psel;
    logic                penable;
    logic                pwrite;
    logic [ADDR_W-1:0]   paddr;
    logic [DATA_W-1:0]   pwdata;
    logic [DATA_W/8-1:0] pstrb;
    logic [DATA_W-1:0]   prdata;
    logic                pready;
    logic                pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
               prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               psel, penable, pwrite, paddr, pwdata, pstrb
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
               prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               psel, penable, pwrite, paddr, pwdata, pstrb
    );

endinterface

// File: rtl/apb_wait_timer.sv
// Watchdog for APB wait states: counts stalled ACCESS cycles, flags the last allowed one.
// Latency: expired is a decode of the count register, no input-to-output path.
// Backpressure: counting stops once expired until the next clear.
module apb_wait_timer
    import apb_initiator_pkg::*;
#(
    parameter int CYCLES = APB_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CNT_W = $clog2(CYCLES) + 1;

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == CNT_W'(CYCLES - 1));

endmodule

// File: rtl/apb_initiator.sv
// APB4 single-outstanding requester: command -> SETUP/ACCESS -> response. Optional APB_TIMEOUT_EN watchdog.
// Latency: cmd accepted cycle 0, SETUP 1, ACCESS 2, rsp_valid 3 plus one cycle per pready=0 wait state.
// Backpressure: cmd_ready only in IDLE; the response is held stable until rsp_ready.
module apb_initiator
    import apb_initiator_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = APB_TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    apb_initiator_if.master bus
);
    localparam int STRB_W = DATA_W / 8;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] strb;
    } cmd_t;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("apb_initiator: TIMEOUT_CYCLES must be at least 2");
    end

    state_t            state;
    state_t            state_nxt;
    cmd_t              cmd_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;
    logic              rsp_timeout_q;
    logic              timeout_hit;

`ifdef APB_TIMEOUT_EN
    apb_wait_timer #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state == SETUP),
        .enable  ((state == ACCESS) && !bus.pready),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.cmd_valid) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (bus.pready || timeout_hit) state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read transfers keep pstrb at zero, so the mask is applied at capture time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q <= '0;
        end else if (state == IDLE && bus.cmd_valid) begin
            cmd_q.write <= bus.cmd_write;
            cmd_q.addr  <= bus.cmd_addr;
            cmd_q.wdata <= bus.cmd_wdata;
            cmd_q.strb  <= bus.cmd_write ? bus.cmd_strb : '0;
        end
    end

    // pready wins over a watchdog expiry landing in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else if (state == ACCESS) begin
            if (bus.pready) begin
                rsp_rdata_q   <= cmd_q.write ? '0 : bus.prdata;
                rsp_err_q     <= bus.pslverr;
                rsp_timeout_q <= 1'b0;
            end else if (timeout_hit) begin
                rsp_rdata_q   <= '0;
                rsp_err_q     <= 1'b1;
                rsp_timeout_q <= 1'b1;
            end
        end
    end

    assign bus.cmd_ready   = (state == IDLE);
    assign bus.rsp_valid   = (state == RESP);
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;

    assign bus.psel    = (state == SETUP) || (state == ACCESS);
    assign bus.penable = (state == ACCESS);
    assign bus.pwrite  = cmd_q.write;
    assign bus.paddr   = cmd_q.addr;
    assign bus.pwdata  = cmd_q.wdata;
    assign bus.pstrb   = cmd_q.strb;

endmodule

// File: tb/tb_apb_initiator.sv
// Directed bench for apb_initiator; define APB_TIMEOUT_EN on both DUT and bench to cover the watchdog.
module tb_apb_initiator;
    import apb_initiator_pkg::*;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    apb_initiator_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    apb_initiator #(
        .ADDR_W         (12),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "bench timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic wr, input logic [11:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        bus.cmd_strb  = strb;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 1000",
                     {bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout});
        end
        checks++;
        if ({bus.psel, bus.penable, bus.pwrite, bus.pstrb} !== 7'b0) begin
            errors++;
            $display("FAIL reset_apb_ctrl: got %b expected 0000000",
                     {bus.psel, bus.penable, bus.pwrite, bus.pstrb});
        end
        checks++;
        if ({bus.paddr, bus.pwdata, bus.rsp_rdata} !== 76'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", {bus.paddr, bus.pwdata, bus.rsp_rdata});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write();
        bus.pready  = 1'b1;
        bus.pslverr = 1'b0;
        bus.prdata  = 32'hDEAD_BEEF;
        offer(1'b1, TCR, 32'h0000_0103, 4'hF);
        tick();
        bus.cmd_valid = 1'b0;
        checks++;
        if ({bus.psel, bus.penable, bus.cmd_ready, bus.pwrite} !== 4'b1001 ||
            bus.paddr !== 12'h000 || bus.pwdata !== 32'h0000_0103) begin
            errors++;
            $display("FAIL wr_setup: got sel/en/rdy/wr=%b addr=%h data=%h expected 1001 000 00000103",
                     {bus.psel, bus.penable, bus.cmd_ready, bus.pwrite}, bus.paddr, bus.pwdata);
        end
        tick();
        checks++;
        if ({bus.psel, bus.penable, bus.rsp_valid} !== 3'b110 || bus.pstrb !== 4'hF) begin
            errors++;
            $display("FAIL wr_access: got sel/en/rv=%b pstrb=%h expected 110 f",
                     {bus.psel, bus.penable, bus.rsp_valid}, bus.pstrb);
        end
        tick();
        checks++;
        if ({bus.rsp_valid, bus.rsp_err, bus.psel, bus.penable} !== 4'b1000 ||
            bus.rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL wr_resp: got rv/err/sel/en=%b rdata=%h expected 1000 00000000",
                     {bus.rsp_valid, bus.rsp_err, bus.psel, bus.penable}, bus.rsp_rdata);
        end
        checks++;
        if (bus.paddr !== 12'h000 || bus.pwdata !== 32'h0000_0103 || bus.pwrite !== 1'b1) begin
            errors++;
            $display("FAIL wr_hold: got addr=%h data=%h wr=%b expected 000 00000103 1",
                     bus.paddr, bus.pwdata, bus.pwrite);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        checks++;
        if ({bus.cmd_ready, bus.rsp_valid} !== 2'b10) begin
            errors++;
            $display("FAIL wr_idle: got rdy/rv=%b expected 10", {bus.cmd_ready, bus.rsp_valid});
        end
    endtask

    task automatic test_read_wait();
        int en_cycles;
        en_cycles = 0;
        bus.pready  = 1'b0;
        bus.pslverr = 1'b1;
        bus.prdata  = 32'hFFFF_FFFF;
        offer(1'b0, TCMP0, 32'h1234_5678, 4'hF);
        tick();
        bus.cmd_valid = 1'b0;
        checks++;
        if (bus.pstrb !== 4'h0 || bus.pwrite !== 1'b0 || bus.paddr !== 12'h00C) begin
            errors++;
            $display("FAIL rd_setup: got pstrb=%h wr=%b addr=%h expected 0 0 00c",
                     bus.pstrb, bus.pwrite, bus.paddr);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            if (bus.penable === 1'b1) en_cycles++;
            if (i == 3) begin
                bus.pready  = 1'b1;
                bus.pslverr = 1'b0;
            end
            tick();
        end
        bus.pready = 1'b0;
        checks++;
        if (en_cycles != 4) begin
            errors++;
            $display("FAIL rd_wait_cycles: got %0d expected 4", en_cycles);
        end
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hFFFF_FFFF || bus.rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL rd_resp: got rv=%b rdata=%h err=%b expected 1 ffffffff 0",
                     bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_slverr();
        bus.pready  = 1'b1;
        bus.pslverr = 1'b1;
        offer(1'b1, TCR, 32'h0000_0900, 4'h2);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        checks++;
        if (bus.pstrb !== 4'h2) begin
            errors++;
            $display("FAIL err_pstrb: got %h expected 2", bus.pstrb);
        end
        tick();
        bus.pslverr = 1'b0;
        checks++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_timeout} !== 3'b110 || bus.rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL err_resp: got rv/err/to=%b rdata=%h expected 110 00000000",
                     {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, bus.rsp_rdata);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int bad;
        bad = 0;
        bus.pready  = 1'b1;
        bus.pslverr = 1'b1;
        bus.prdata  = 32'hA5A5_0001;
        offer(1'b0, TDR0, 32'h0, 4'h0);
        tick();
        offer(1'b0, TISR, 32'h0, 4'h0);
        tick();
        tick();
        bus.pslverr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.prdata  = 32'h1111_0000 + 32'(i);
            bus.pslverr = i[0];
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hA5A5_0001 || bus.rsp_err !== 1'b1 ||
                bus.cmd_ready !== 1'b0 || bus.psel !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_stable: got %0d unstable cycles expected 0", bad);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got rdy=%b rv=%b expected 1 0", bus.cmd_ready, bus.rsp_valid);
        end
        tick();
        bus.cmd_valid = 1'b0;
        bus.prdata    = 32'h1234_5678;
        bus.pslverr   = 1'b0;
        checks++;
        if (bus.psel !== 1'b1 || bus.penable !== 1'b0 || bus.paddr !== 12'h018) begin
            errors++;
            $display("FAIL b2b_setup: got sel=%b en=%b addr=%h expected 1 0 018",
                     bus.psel, bus.penable, bus.paddr);
        end
        tick();
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h1234_5678 || bus.rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_resp: got rv=%b rdata=%h err=%b expected 1 12345678 0",
                     bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_stuck_pready();
        int n;
        n = 0;
        bus.pready = 1'b0;
        bus.prdata = 32'hCAFE_F00D;
        offer(1'b0, TIER, 32'h0, 4'h0);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
`ifdef APB_TIMEOUT_EN
        while (bus.penable === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL to_access_cycles: got %0d expected 16", n);
        end
        checks++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.psel} !== 4'b1110 ||
            bus.rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL to_resp: got rv/err/to/sel=%b rdata=%h expected 1110 00000000",
                     {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.psel}, bus.rsp_rdata);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        offer(1'b0, TIER, 32'h0, 4'h0);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < 15; i++) tick();
        checks++;
        if (bus.penable !== 1'b1) begin
            errors++;
            $display("FAIL to_last_access: got en=%b expected 1", bus.penable);
        end
        bus.pready = 1'b1;
        bus.prdata = 32'h0000_0055;
        tick();
        bus.pready = 1'b0;
        checks++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_timeout} !== 3'b100 || bus.rsp_rdata !== 32'h55) begin
            errors++;
            $display("FAIL to_pready_wins: got rv/err/to=%b rdata=%h expected 100 00000055",
                     {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, bus.rsp_rdata);
        end
`else
        for (int i = 0; i < 30; i++) begin
            if (bus.penable !== 1'b1 || bus.rsp_valid !== 1'b0) n++;
            tick();
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL stuck_hold: got %0d cycles out of ACCESS expected 0", n);
        end
        bus.pready = 1'b1;
        tick();
        bus.pready = 1'b0;
        checks++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_timeout} !== 3'b100 || bus.rsp_rdata !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL stuck_resp: got rv/err/to=%b rdata=%h expected 100 cafef00d",
                     {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, bus.rsp_rdata);
        end
`endif
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int bad;
        bad = 0;
        bus.pready = 1'b0;
        offer(1'b1, THCSR, 32'h0000_00AA, 4'h1);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        checks++;
        if (bus.penable !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_access: got en=%b expected 1", bus.penable);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.psel !== 1'b0 || bus.penable !== 1'b0) begin
            errors++;
            $display("FAIL rst_async_drop: got sel=%b en=%b expected 0 0", bus.psel, bus.penable);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.pready = 1'b1;
        tick();
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_release_ready: got %b expected 1", bus.cmd_ready);
        end
        for (int i = 0; i < 4; i++) begin
            if (bus.rsp_valid !== 1'b0 || bus.psel !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rst_no_rsp: got %0d cycles with activity expected 0", bad);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_strb  = '0;
        bus.rsp_ready = 1'b0;
        bus.prdata    = '0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;

        test_reset();
        test_write();
        test_read_wait();
        test_slverr();
        test_back_to_back();
        test_stuck_pready();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_initiator.md
# apb_initiator

APB4 requester that converts single-beat command requests from a local controller (CPU-side sequencer or test harness) into APB setup/access transfers toward the timer register file and other APB slaves on the peripheral bus. It owns the psel/penable sequencing and wait-state handling, and returns read data or slave error on a response handshake. One transfer is outstanding at a time.

## Interface
Parameters:
- ADDR_W, 12, APB address width.
- DATA_W, 32, APB data width; strobe width is DATA_W/8.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles before abort (used only with APB_TIMEOUT_EN).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- cmd_strb  in  DATA_W/8  byte strobes for writes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  read data (0 for writes).
- rsp_err  out  1  pslverr sampled, or timeout.
- rsp_timeout  out  1  transfer aborted by watchdog (tied 0 without APB_TIMEOUT_EN).
- psel, penable, pwrite  out  1 each  APB control.
- paddr  out  ADDR_W; pwdata  out  DATA_W; pstrb  out  DATA_W/8.
- prdata  in  DATA_W; pready  in  1; pslverr  in  1.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready=1. On cmd_valid, latch write/addr/wdata/strb into command registers, go SETUP.
- SETUP: psel=1, penable=0, APB outputs driven from latched command; unconditionally go ACCESS.
- ACCESS: psel=1, penable=1, outputs stable. When pready=1: capture prdata (reads only; writes capture 0) and pslverr into response registers, go RESP. pready=0 holds ACCESS.
- RESP: rsp_valid=1, psel=penable=0. On rsp_ready go IDLE. Response registers stable until handshake.
- pstrb = latched cmd_strb for writes, forced 0 for reads (APB4 rule).
- paddr/pwdata/pwrite/pstrb hold last value in IDLE/RESP (no toggling between transfers).
- cmd_ready is 0 in SETUP, ACCESS, RESP; commands offered then are not lost, just stalled.
- pslverr and prdata are ignored in any cycle where psel&penable&pready is not true.
- Reset mid-transfer: all state to IDLE immediately (async), psel/penable drop in the same cycle; no response generated for the aborted transfer.

## Timing
- Reset values: cmd_ready=1 (state IDLE), rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, pstrb=0.
- Cycle 0 command handshake; cycle 1 SETUP; cycle 2 first ACCESS; with zero wait states rsp_valid rises cycle 3. Each pready=0 cycle adds one.
- rsp_ready asserted in first RESP cycle: IDLE on cycle 4, next command accepted cycle 4 → minimum 4 cycles per transfer.
- All outputs registered or decoded from the state register only; no combinational path from pready/prdata/pslverr/cmd_* to any output.

## Configuration
- APB_TIMEOUT_EN defined: wait counter clears on SETUP→ACCESS, increments each ACCESS cycle with pready=0; when count reaches TIMEOUT_CYCLES-1 with pready still 0, go RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0, psel dropped. pready=1 in that same cycle wins (normal completion).
- Undefined: no counter, ACCESS waits indefinitely, rsp_timeout tied 0.

## Structure
- Package apb_initiator_pkg: state enum (IDLE, SETUP, ACCESS, RESP), default widths, timer register offsets (TCR 0x00, TDR0 0x04, TDR1 0x08, TCMP0 0x0C, TCMP1 0x10, TIER 0x14, TISR 0x18, THCSR 0x1C) for benches.
- One sub-module apb_wait_timer: the watchdog counter (clear, enable, expired output), instantiated only under APB_TIMEOUT_EN.

## Test plan
- Write 0x000 data 0x0000_0103 strb 0xF, slave pready=1 → SETUP cycle 1, ACCESS cycle 2 with pstrb=0xF, rsp_valid cycle 3, rsp_err=0.
- Read 0x00C, slave returns 0xFFFF_FFFF after 3 wait states → penable high 4 cycles, pstrb=0, rsp_rdata=0xFFFF_FFFF on cycle 6.
- Write 0x000 data 0x0000_0900 strb 0x2, slave asserts pslverr with pready → rsp_err=1, rsp_timeout=0.
- Hold rsp_ready=0 for 5 cycles with cmd_valid=1 → rsp stable, cmd_ready=0, psel=0 throughout; second command accepted the cycle IDLE is reached.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES=16, pready stuck 0 → exactly 16 ACCESS cycles, then rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- Assert rst_n=0 during ACCESS → psel/penable 0 immediately, cmd_ready=1 after release, no rsp_valid.
